// File: rtl/wb_pkg.sv
// Shared types and load-type encodings for the write-back stage.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_pipelined_load_align.sv
// Combinational load-data alignment, sign/zero extension and fault detection.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                   funct3,
  input  logic [$clog2(XLEN/8)-1:0]    offset,
  input  logic [XLEN-1:0]              raw,
  output logic [XLEN-1:0]              data,
  output logic                         fault
);

  logic [2:0]      off3;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  logic            misaligned;
  logic            illegal;

  always_comb begin
    off3       = 3'(offset);
    shifted    = raw >> {offset, 3'b000};
    ext        = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  ext = XLEN'($signed(shifted[7:0]));
      F3_LBU: ext = XLEN'(shifted[7:0]);
      F3_LH: begin
        ext        = XLEN'($signed(shifted[15:0]));
        misaligned = off3[0];
      end
      F3_LHU: begin
        ext        = XLEN'(shifted[15:0]);
        misaligned = off3[0];
      end
      // With XLEN=32 the sign-extending cast degenerates to a pass-through.
      F3_LW: begin
        ext        = XLEN'($signed(shifted[31:0]));
        misaligned = |off3[1:0];
      end
      F3_LWU: begin
        ext        = XLEN'(shifted[31:0]);
        misaligned = |off3[1:0];
        illegal    = (XLEN == 32);
      end
      F3_LD: begin
        ext        = shifted;
        misaligned = |off3;
        illegal    = (XLEN == 32);
      end
      default: illegal = 1'b1;
    endcase
    fault = misaligned | illegal;
    data  = fault ? '0 : ext;
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Write-back stage: MEM/WB register, load alignment, result mux, retire counter.
module wb_stage_pipelined
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_w,
  input  logic             flush_w,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic [1:0]       result_src_m,
  input  logic [2:0]       funct3_m,
  input  logic [4:0]       rd_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus_4_m,
  input  logic [XLEN-1:0]  imm_m,
  output logic             reg_write_w,
  output logic [4:0]       rd_w,
  output logic [XLEN-1:0]  result_w,
  output logic             retire_w,
  output logic             load_fault_w,
  output logic [CNT_W-1:0] instret_w
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic             valid_q;
  logic             reg_write_q;
  result_src_e      result_src_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  rdata_q;
  logic [XLEN-1:0]  pc4_q;
  logic [XLEN-1:0]  imm_q;
  logic [CNT_W-1:0] instret_q;

  logic [XLEN-1:0]  load_data;
  logic             align_fault;
  logic             fault;

  // A flushed bubble clears every field so it can never raise a stale load fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= RES_ALU;
      funct3_q     <= '0;
      rd_q         <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
      imm_q        <= '0;
    end else if (flush_w) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= RES_ALU;
      funct3_q     <= '0;
      rd_q         <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
      imm_q        <= '0;
    end else if (!stall_w) begin
      valid_q      <= valid_m;
      reg_write_q  <= reg_write_m;
      result_src_q <= result_src_e'(result_src_m);
      funct3_q     <= funct3_m;
      rd_q         <= rd_m;
      alu_q        <= alu_result_m;
      rdata_q      <= read_data_m;
      pc4_q        <= pc_plus_4_m;
      imm_q        <= imm_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        instret_q <= '0;
    else if (retire_w) instret_q <= instret_q + 1'b1;
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (funct3_q),
    .offset (alu_q[OFF_W-1:0]),
    .raw    (rdata_q),
    .data   (load_data),
    .fault  (align_fault)
  );

  always_comb begin
    fault = (result_src_q == RES_LOAD) & align_fault;
    case (result_src_q)
      RES_ALU:  result_w = alu_q;
      RES_LOAD: result_w = load_data;
      RES_PC4:  result_w = pc4_q;
      RES_IMM:  result_w = imm_q;
      default:  result_w = alu_q;
    endcase
  end

  assign reg_write_w  = valid_q & reg_write_q & (rd_q != 5'd0) & ~fault;
  assign rd_w         = rd_q;
  assign retire_w     = valid_q & ~stall_w;
  assign load_fault_w = fault;
  assign instret_w    = instret_q;

endmodule

// File: doc/wb_stage_pipelined.md
# wb_stage_pipelined

Parametrised write-back stage with its own MEM/WB pipeline register, stall and flush control, and load-data alignment with sign and zero extension. It selects one of four result sources and drives the register-file write port and the WB forwarding path. It also counts retired instructions. It sits between the memory stage and the register file and replaces the purely combinational write-back mux.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; legal values 32 or 64.
- `CNT_W`, default 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall_w`  in  1  hold the MEM/WB register.
- `flush_w`  in  1  load a bubble into the MEM/WB register.
- `valid_m`  in  1  memory-stage instruction valid.
- `reg_write_m`  in  1  instruction writes rd.
- `result_src_m`  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- `funct3_m`  in  3  load type.
- `rd_m`  in  5  destination register.
- `alu_result_m`  in  XLEN  ALU result / effective address.
- `read_data_m`  in  XLEN  raw data-memory word.
- `pc_plus_4_m`  in  XLEN  link value.
- `imm_m`  in  XLEN  U-type immediate (LUI).
- `reg_write_w`  out  1  register-file write enable.
- `rd_w`  out  5  register-file write address.
- `result_w`  out  XLEN  write data and forwarding value.
- `retire_w`  out  1  one-cycle pulse per retired instruction.
- `load_fault_w`  out  1  misaligned or illegal load in WB.
- `instret_w`  out  CNT_W  retired-instruction count.

## Operation
- **MEM/WB register.** All `*_m` inputs plus `valid_m` are captured on the rising edge.
  - `flush_w=1`: capture a bubble (`valid=0`, `reg_write=0`). Flush has priority over stall.
  - `stall_w=1` with no flush: hold the register contents.
  - Otherwise: capture the inputs.
- **Load alignment.** Byte offset is `alu_result[log2(XLEN/8)-1:0]`. Data is shifted right by `offset×8`, then extended:
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half.
  - 101 LHU: zero-extend half.
  - 010 LW: sign-extend word when XLEN=64; pass through when XLEN=32.
  - 110 LWU: zero-extend word; XLEN=64 only.
  - 011 LD: pass through; XLEN=64 only.
- **Load fault.** The load is faulted when either condition holds:
  - it is misaligned: half with `offset[0]=1`, word with `offset[1:0]≠0`, or double with `offset[2:0]≠0`;
  - its funct3 is illegal for XLEN: 111 always, and 011/110 when XLEN=32.
- **Effect of a load fault.** When `result_src=01` and the load is faulted:
  - `load_fault_w=1`;
  - the load data is forced to 0;
  - `reg_write_w` is suppressed.
- **Result mux.** Selects ALU, aligned load data, PC+4 or immediate according to `result_src`.
- **`reg_write_w`** = `valid_q & reg_write_q & (rd_q≠0) & ~fault`. Writes to x0 are never asserted.
- **`retire_w`** = `valid_q & ~stall_w`. A faulted load still retires; trap handling happens upstream.
- **`instret_w`** increments by 1 on each cycle where `retire_w=1`. It wraps to 0 at `2^CNT_W−1`.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - `valid_q=0`, `reg_write_q=0`, all data registers 0, `instret_w=0`;
  - hence `reg_write_w=0`, `rd_w=0`, `result_w=0`, `retire_w=0`, `load_fault_w=0`.
- Reset asserted mid-operation drops the in-flight instruction, and it is not counted.
- Latency: 1 cycle from the `*_m` inputs to the WB outputs.
- All outputs are combinational from registered state. `retire_w` is the exception: it also depends on the live `stall_w`.
- Stall held for N cycles: outputs stay stable and `reg_write_w` stays asserted. The repeated write is idempotent. `retire_w` stays 0 until the stall releases.
- Stall and flush together: the bubble is loaded. `retire_w` for the current instruction is 0 because `stall_w=1`, so that instruction is cancelled uncounted.
- `instret_w` reflects retirements up to the previous edge.

## Structure
- Package `wb_pkg` holds:
  - the `result_src_e` enum (`RES_ALU`, `RES_LOAD`, `RES_PC4`, `RES_IMM`);
  - load funct3 constants (`F3_LB` … `F3_LWU`).
- One combinational sub-module, `load_align`, parametrised by XLEN. Inputs: `funct3`, `offset`, `raw`. Outputs: `data`, `fault`.
- The pipeline register, mux, counter and enables stay at top level.

## Test plan
- **Reset:** drive `rst_n=0` asynchronously mid-cycle → all outputs 0 immediately. After release, with no valid input, `instret_w` stays 0.
- **LB sign extension (XLEN=32):** `read_data=0x80FF7F01`, `alu_result=0x1002`, funct3 000 → `result_w=0xFFFFFFFF`. Same with LBU → `0x000000FF`. With offset 3 → `0xFFFFFF80` (LB) / `0x00000080` (LBU).
- **Misaligned and illegal loads:** LH at addr `0x1001` → `load_fault_w=1`, `result_w=0`, `reg_write_w=0`, `retire_w=1`. funct3 011 with XLEN=32 → same response.
- **x0 write:** ALU op with `rd=0` → `reg_write_w=0`, `retire_w=1`, and `instret` increments.
- **Stall and flush:** JAL with `pc_plus_4=0x104` and `rd=1` held by 3 stall cycles → `result_w=0x104` stable, `reg_write_w=1` throughout, `instret` +1 only after release. Asserting stall and flush together → bubble loaded, no increment.
- **Counter wrap (CNT_W=4):** after 15 retirements `instret_w=15`; one more → 0. LD with XLEN=64 at offset 0 passes `0x8000000000000001` unchanged.
